// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 message feeder.
package sha3_pkg;

    localparam int SHA3_WORD_W         = 32;
    localparam int SHA3_BYTE_W         = 8;
    localparam int SHA3_BYTES_PER_WORD = 4;

    // FILL: collecting bytes, ISSUE: data word waiting for the core,
    // TAIL: extra zero terminating word, DONE: message finished until reset.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        TAIL  = 2'd2,
        DONE  = 2'd3
    } packer_state_t;

endpackage

// File: rtl/sha3_byte_packer.sv
// Packs a valid/ready byte stream big-endian into 32-bit words for the
// low-throughput SHA-3 core, adding the zero terminating word when the
// message length is a multiple of four.
//
// Handshake: a byte transfers on a rising edge where s_valid && s_ready.
// The source holds s_byte/s_last stable while s_valid is high and s_ready
// is low. Toward the core, core_in_ready is a single-cycle strobe that is
// only raised while buffer_full is low; the word it carries is registered.
import sha3_pkg::*;

module sha3_byte_packer #(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SHA3_BYTE_W-1:0] s_byte,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic                   buffer_full,
    output logic [SHA3_WORD_W-1:0] core_in,
    output logic                   core_in_ready,
    output logic                   core_is_last,
    output logic [1:0]             core_byte_num,
    output logic                   done,
    output logic [CNT_W-1:0]       msg_bytes,
    output packer_state_t          dbg_state
);

    packer_state_t          state;
    packer_state_t          state_next;

    logic [SHA3_WORD_W-1:0] acc;
    logic [1:0]             fill;
    logic                   last_q;
    logic                   tail_q;
    logic [1:0]             bn_q;
    logic [SHA3_WORD_W-1:0] core_in_q;

    logic                   accept;
    logic                   word_done;
    logic                   issue_fire;
    logic [SHA3_WORD_W-1:0] word_next;
    logic                   last_next;
    logic                   tail_next;
    logic [1:0]             bn_next;

    assign accept     = s_valid && (state == FILL);
    assign word_done  = accept && ((fill == 2'd3) || s_last);
    assign issue_fire = (state == ISSUE) && !buffer_full;
    assign last_next  = s_last && (fill != 2'd3);
    assign tail_next  = s_last && (fill == 2'd3);
    assign bn_next    = s_last ? (fill + 2'd1) : 2'd0;

    // Accumulator with the incoming byte dropped into its big-endian lane.
    always_comb begin
        word_next = acc;
        case (fill)
            2'd0:    word_next = {s_byte, acc[23:0]};
            2'd1:    word_next = {acc[31:24], s_byte, acc[15:0]};
            2'd2:    word_next = {acc[31:16], s_byte, acc[7:0]};
            default: word_next = {acc[31:8], s_byte};
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; ISSUE and TAIL only advance when the core has room.
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (word_done) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!buffer_full) begin
                    if (last_q) begin
                        state_next = DONE;
                    end else if (tail_q) begin
                        state_next = TAIL;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            TAIL: begin
                if (!buffer_full) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = DONE;
            end
        endcase
    end

    // Output decode; the strobe is suppressed in a reset cycle.
    always_comb begin
        s_ready       = (state == FILL);
        core_in_ready = ((state == ISSUE) || (state == TAIL)) && !buffer_full && !reset;
        done          = (state == DONE);
        dbg_state     = state;
    end

    // Datapath: accumulator, issued-word registers and byte counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            fill      <= 2'd0;
            last_q    <= 1'b0;
            tail_q    <= 1'b0;
            bn_q      <= 2'd0;
            core_in_q <= '0;
            msg_bytes <= '0;
        end else begin
            if (accept) begin
                acc  <= word_next;
                fill <= fill + 2'd1;
                if (msg_bytes != {CNT_W{1'b1}}) begin
                    msg_bytes <= msg_bytes + 1'b1;
                end
                if (word_done) begin
                    core_in_q <= word_next;
                    last_q    <= last_next;
                    tail_q    <= tail_next;
                    bn_q      <= bn_next;
                end
            end
            if (issue_fire && !last_q && !tail_q) begin
                acc  <= '0;
                fill <= 2'd0;
            end
            // Terminating word: zero data, flagged last with zero valid bytes.
            if (issue_fire && tail_q) begin
                core_in_q <= '0;
                last_q    <= 1'b1;
                bn_q      <= 2'd0;
            end
        end
    end

    assign core_in       = core_in_q;
    assign core_is_last  = last_q;
    assign core_byte_num = bn_q;

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Self-checking bench for sha3_byte_packer: directed scenarios plus random
// messages checked against a word-list model built from the message bytes.
import sha3_pkg::*;

module tb_sha3_byte_packer;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    s_byte;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          buffer_full;
    logic [31:0]   core_in;
    logic          core_in_ready;
    logic          core_is_last;
    logic [1:0]    core_byte_num;
    logic          done;
    logic [31:0]   msg_bytes;
    packer_state_t dbg_state;

    int errors = 0;
    int checks = 0;

    logic [7:0]  msg[$];
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    logic [1:0]  exp_bn_q[$];
    logic [31:0] got_word[$];
    logic        got_last[$];
    logic [1:0]  got_bn[$];
    int          full_strobes = 0;
    bit          bf_rand_en = 1'b0;

    sha3_byte_packer #(.CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_byte        (s_byte),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .buffer_full   (buffer_full),
        .core_in       (core_in),
        .core_in_ready (core_in_ready),
        .core_is_last  (core_is_last),
        .core_byte_num (core_byte_num),
        .done          (done),
        .msg_bytes     (msg_bytes),
        .dbg_state     (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Strobe collector, sampled away from the active edge.
    always @(negedge clk) begin
        if (core_in_ready === 1'b1) begin
            got_word.push_back(core_in);
            got_last.push_back(core_is_last);
            got_bn.push_back(core_byte_num);
            if (buffer_full) full_strobes++;
        end
    end

    // Random back-pressure from the core when enabled.
    always @(posedge clk) begin
        if (bf_rand_en) begin
            #1 buffer_full = ($urandom_range(0, 3) == 0);
        end
    end

    // Reference: expected word stream derived from the message bytes.
    task automatic build_expected();
        int n, nw, rem;
        logic [31:0] w;
        exp_q.delete(); exp_last_q.delete(); exp_bn_q.delete();
        n   = msg.size();
        nw  = (n + 3) / 4;
        rem = n % 4;
        for (int wi = 0; wi < nw; wi++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (wi * 4 + k < n) w = w | (32'(msg[wi * 4 + k]) << (24 - 8 * k));
            end
            exp_q.push_back(w);
            exp_last_q.push_back((wi == nw - 1) && (rem != 0));
            exp_bn_q.push_back((wi == nw - 1) ? 2'(rem) : 2'd0);
        end
        if (rem == 0) begin
            exp_q.push_back(32'h0);
            exp_last_q.push_back(1'b1);
            exp_bn_q.push_back(2'd0);
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        s_valid = 1'b0; s_last = 1'b0; s_byte = 8'h00;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        got_word.delete(); got_last.delete(); got_bn.delete();
        full_strobes = 0;
    endtask

    task automatic send_bytes(input bit gaps, input bit mark_last);
        for (int i = 0; i < msg.size(); i++) begin
            bit ok;
            int cyc;
            if (gaps) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_byte  = msg[i];
            s_last  = mark_last && (i == msg.size() - 1);
            ok  = 1'b0;
            cyc = 0;
            while (!ok && cyc < 1000) begin
                @(negedge clk);
                ok = s_ready;
                @(posedge clk); #1;
                cyc++;
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL accept_timeout: byte %0d not accepted, s_ready=%b, required 1", i, s_ready);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        @(negedge clk);
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b, required 1", done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_byte = 8'h00; buffer_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
        checks++; if (core_in !== 32'h0) begin errors++; $display("FAIL reset_core_in: got %h required 0", core_in); end
        checks++; if (core_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", core_in_ready); end
        checks++; if (core_is_last !== 1'b0) begin errors++; $display("FAIL reset_is_last: got %b required 0", core_is_last); end
        checks++; if (core_byte_num !== 2'd0) begin errors++; $display("FAIL reset_byte_num: got %0d required 0", core_byte_num); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (msg_bytes !== 32'd0) begin errors++; $display("FAIL reset_msg_bytes: got %0d required 0", msg_bytes); end
    endtask

    task automatic test_abc();
        do_reset();
        msg = '{8'h61, 8'h62, 8'h63};
        send_bytes(1'b0, 1'b1);
        @(negedge clk);
        checks++; if (core_in_ready !== 1'b1) begin errors++; $display("FAIL abc_strobe: got %b required 1", core_in_ready); end
        checks++; if (core_in !== 32'h61626300) begin errors++; $display("FAIL abc_word: got %h required 61626300", core_in); end
        checks++; if (core_is_last !== 1'b1) begin errors++; $display("FAIL abc_is_last: got %b required 1", core_is_last); end
        checks++; if (core_byte_num !== 2'd3) begin errors++; $display("FAIL abc_byte_num: got %0d required 3", core_byte_num); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL abc_s_ready_issue: got %b required 0", s_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abc_done: got %b required 1", done); end
        checks++; if (core_in_ready !== 1'b0) begin errors++; $display("FAIL abc_single_strobe: got %b required 0", core_in_ready); end
        checks++; if (msg_bytes !== 32'd3) begin errors++; $display("FAIL abc_msg_bytes: got %0d required 3", msg_bytes); end
    endtask

    task automatic test_after_done();
        // Continues from the finished "abc" message.
        s_valid = 1'b1; s_byte = 8'h77; s_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL done_s_ready: cycle %0d got %b required 0", i, s_ready); end
            checks++; if (core_in_ready !== 1'b0) begin errors++; $display("FAIL done_strobe: cycle %0d got %b required 0", i, core_in_ready); end
        end
        @(posedge clk); #1 s_valid = 1'b0;
        checks++; if (got_word.size() !== 1) begin errors++; $display("FAIL done_strobe_count: got %0d required 1", got_word.size()); end
        checks++; if (msg_bytes !== 32'd3) begin errors++; $display("FAIL done_msg_bytes: got %0d required 3", msg_bytes); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b required 1", done); end
    endtask

    task automatic test_four();
        do_reset();
        msg = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_bytes(1'b0, 1'b1);
        wait_done(50);
        checks++;
        if (got_word.size() !== 2) begin
            errors++; $display("FAIL four_count: got %0d strobes required 2", got_word.size());
        end else begin
            if (got_word[0] !== 32'h01020304 || got_last[0] !== 1'b0) begin
                errors++; $display("FAIL four_word0: got %h last %b required 01020304 last 0", got_word[0], got_last[0]);
            end
            checks++;
            if (got_word[1] !== 32'h0 || got_last[1] !== 1'b1 || got_bn[1] !== 2'd0) begin
                errors++; $display("FAIL four_tail: got %h last %b bn %0d required 0 last 1 bn 0", got_word[1], got_last[1], got_bn[1]);
            end
        end
        checks++; if (msg_bytes !== 32'd4) begin errors++; $display("FAIL four_msg_bytes: got %0d required 4", msg_bytes); end
    endtask

    task automatic test_five();
        do_reset();
        msg = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send_bytes(1'b0, 1'b1);
        wait_done(50);
        checks++;
        if (got_word.size() !== 2) begin
            errors++; $display("FAIL five_count: got %0d strobes required 2", got_word.size());
        end else begin
            if (got_word[0] !== 32'h11121314 || got_last[0] !== 1'b0) begin
                errors++; $display("FAIL five_word0: got %h last %b required 11121314 last 0", got_word[0], got_last[0]);
            end
            checks++;
            if (got_word[1] !== 32'h15000000 || got_last[1] !== 1'b1 || got_bn[1] !== 2'd1) begin
                errors++; $display("FAIL five_word1: got %h last %b bn %0d required 15000000 last 1 bn 1", got_word[1], got_last[1], got_bn[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        msg = '{8'h61, 8'h62};
        send_bytes(1'b0, 1'b0);
        buffer_full = 1'b1;
        msg = '{8'h63};
        send_bytes(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (core_in_ready !== 1'b0) begin errors++; $display("FAIL bp_strobe: cycle %0d got %b required 0", i, core_in_ready); end
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready: cycle %0d got %b required 0", i, s_ready); end
            checks++; if (core_in !== 32'h61626300) begin errors++; $display("FAIL bp_word_stable: cycle %0d got %h required 61626300", i, core_in); end
        end
        @(posedge clk); #1 buffer_full = 1'b0;
        @(negedge clk);
        checks++; if (core_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b required 1", core_in_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b required 1", done); end
        checks++; if (got_word.size() !== 1) begin errors++; $display("FAIL bp_strobe_count: got %0d required 1", got_word.size()); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        msg = '{8'haa, 8'hbb};
        send_bytes(1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || core_in_ready !== 1'b0 || core_in !== 32'h0 || core_is_last !== 1'b0 ||
            core_byte_num !== 2'd0 || done !== 1'b0 || msg_bytes !== 32'd0) begin
            errors++;
            $display("FAIL midreset_outputs: rdy %b str %b in %h last %b bn %0d done %b cnt %0d required 1 0 0 0 0 0 0",
                     s_ready, core_in_ready, core_in, core_is_last, core_byte_num, done, msg_bytes);
        end
        // Reset arriving in the issue cycle must swallow the strobe.
        msg = '{8'hde, 8'had, 8'hbe};
        send_bytes(1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (core_in_ready !== 1'b0) begin errors++; $display("FAIL reset_cycle_strobe: got %b required 0", core_in_ready); end
        @(posedge clk); #1 reset = 1'b0;
        got_word.delete(); got_last.delete(); got_bn.delete();
        msg = '{8'h61, 8'h62, 8'h63};
        send_bytes(1'b0, 1'b1);
        wait_done(50);
        checks++;
        if (got_word.size() !== 1 || got_word[0] !== 32'h61626300) begin
            errors++; $display("FAIL midreset_abc: got %0d strobes first %h required 1 strobe 61626300",
                               got_word.size(), (got_word.size() > 0) ? got_word[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        for (int m = 0; m < 10; m++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 13);
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
            build_expected();
            bf_rand_en = 1'b1;
            send_bytes(1'b1, 1'b1);
            wait_done(500);
            bf_rand_en = 1'b0;
            @(posedge clk); #2 buffer_full = 1'b0;
            checks++;
            if (got_word.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand_count: msg %0d len %0d got %0d strobes required %0d", m, n, got_word.size(), exp_q.size());
            end else begin
                for (int w = 0; w < exp_q.size(); w++) begin
                    checks++;
                    if (got_word[w] !== exp_q[w] || got_last[w] !== exp_last_q[w] || got_bn[w] !== exp_bn_q[w]) begin
                        errors++;
                        $display("FAIL rand_word: msg %0d word %0d got %h/%b/%0d required %h/%b/%0d", m, w,
                                 got_word[w], got_last[w], got_bn[w], exp_q[w], exp_last_q[w], exp_bn_q[w]);
                    end
                end
            end
            checks++; if (msg_bytes !== 32'(n)) begin errors++; $display("FAIL rand_msg_bytes: got %0d required %0d", msg_bytes, n); end
            checks++; if (full_strobes !== 0) begin errors++; $display("FAIL rand_strobe_while_full: got %0d required 0", full_strobes); end
        end
    endtask

    initial begin
        s_valid = 1'b0; s_last = 1'b0; s_byte = 8'h00; buffer_full = 1'b0; reset = 1'b1;
        test_reset();
        test_abc();
        test_after_done();
        test_four();
        test_five();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha3_byte_packer.md
# sha3_byte_packer

Upstream feeder for the low-throughput SHA-3 core. It accepts a message as a valid/ready byte stream and packs it big-endian into 32-bit words. It drives the core's `in`, `in_ready`, `is_last` and `byte_num` inputs while honouring `buffer_full`. It also generates the extra zero-byte terminating word the core requires when the message length is a multiple of 4. It replaces the random-number stimulus used in bring-up builds with a real message path.

## Interface
- `CNT_W`, 32: width of the accepted-byte counter `msg_bytes`.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; shared with the SHA-3 core.
- `s_byte` in 8: message byte.
- `s_valid` in 1: `s_byte` valid.
- `s_last` in 1: qualifies `s_byte` as the final message byte. Messages are ≥1 byte.
- `s_ready` out 1: byte accepted when `s_valid && s_ready`.
- `buffer_full` in 1: from the core; no word may be issued while high.
- `core_in` out 32: word to the core's `in`.
- `core_in_ready` out 1: one-cycle issue strobe to the core's `in_ready`.
- `core_is_last` out 1: to the core's `is_last`.
- `core_byte_num` out 2: to the core's `byte_num`.
- `done` out 1: final word issued; stays high until reset.
- `msg_bytes` out `CNT_W`: bytes accepted since reset; saturates at all-ones.

## Operation
- State register values: `FILL`, `ISSUE`, `TAIL`, `DONE`.
- Internal registers:
  - `acc[31:0]`: word accumulator.
  - `fill[1:0]`: bytes currently in `acc`.
  - `last_q`: latched `s_last` of the word being issued.
  - `bn_q[1:0]`: latched byte count for the last word.
- `FILL`:
  - `s_ready=1`.
  - An accepted byte is written to `acc[31-8*fill -: 8]`; `fill` increments mod 4.
  - If `fill==3` or `s_last`, go to `ISSUE`.
  - `last_q = s_last && fill!=3`.
  - `bn_q = s_last ? fill+1 : 0`. This gives values 1–3.
  - A 4th byte with `s_last` sets `last_q=0` and a tail flag `tail_q=1`.
  - Unused low bytes of a partial last word are 0.
- `ISSUE`:
  - `s_ready=0`.
  - `core_in_ready = !buffer_full`, combinational from the state and `buffer_full`.
  - In the issue cycle, the next state depends on the word:
    - `last_q` set → `DONE`.
    - else `tail_q` set → `TAIL`.
    - else → `FILL`, with `acc` cleared to 0 and `fill` cleared to 0.
  - While `buffer_full=1`, hold the state and all outputs stable.
- `TAIL`:
  - `core_in=0`, `core_is_last=1`, `core_byte_num=0`.
  - Issued under the same `buffer_full` rule, then → `DONE`.
- `DONE`:
  - `s_ready=0`, `core_in_ready=0`, `done=1`.
  - Exit only via reset; the core needs a reset per message.
- `core_in`, `core_is_last`, `core_byte_num` are registered and valid whenever `core_in_ready=1`.
- `msg_bytes` increments on every accepted byte and saturates at its maximum.
- Reset values:
  - State `FILL`; `s_ready=1` combinationally after reset.
  - `core_in=0`, `core_in_ready=0`, `core_is_last=0`, `core_byte_num=0`.
  - `done=0`, `msg_bytes=0`, `acc=0`, `fill=0`, `tail_q=0`.

## Timing
- Latency: the word completed by the byte accepted in cycle t appears with `core_in_ready=1` at t+1 if `buffer_full=0` that cycle.
- `s_ready` reasserts the cycle after the issue strobe, so a full 4-byte word costs at least 5 cycles. That rate is adequate for the low-throughput core.
- `core_in_ready` is never high on a cycle where `buffer_full=1`, and is never high for two words carrying the same data.
- `buffer_full` rising in the same cycle `ISSUE` is entered means no strobe that cycle; the word waits.
- Reset mid-message, in any state, discards all partial data. No strobe occurs in the reset cycle.
- `s_valid` with `s_ready=0` is ignored. The source must hold the byte stable until it is accepted.

## Structure
- `sha3_pkg` holds:
  - the `packer_state_t` enum (`FILL`, `ISSUE`, `TAIL`, `DONE`);
  - the constants `SHA3_WORD_W=32`, `SHA3_BYTE_W=8` and `SHA3_BYTES_PER_WORD=4`.
- Single module with no sub-module.
- The top-level wrapper instantiates `sha3_byte_packer` → `sha3_low_throughput` directly.

## Test plan
- "abc": bytes 0x61, 0x62, 0x63 with `s_last` on 0x63 → one strobe, `core_in=0x61626300`, `is_last=1`, `byte_num=3`, `done=1` next cycle, `msg_bytes=3`.
- 0x01, 0x02, 0x03, 0x04 with `s_last` on 0x04 → strobe 1: `0x01020304`, `is_last=0`. Strobe 2: `0x00000000`, `is_last=1`, `byte_num=0`. Then `done`.
- 5 bytes 0x11..0x15 → `0x11121314` with `is_last=0`, then `0x15000000` with `is_last=1`, `byte_num=1`.
- `buffer_full=1` for 10 cycles while in `ISSUE` → `core_in_ready=0` and `s_ready=0` throughout, `core_in` stable. Strobe fires the first cycle `buffer_full=0`.
- Reset after 2 bytes of a word → all outputs at reset values next cycle. A new "abc" then yields `0x61626300`.
- After `done`, drive `s_valid=1` for 5 cycles → `s_ready=0`, no strobes, `msg_bytes` unchanged.
